// File: rtl/reorder_buffer_pkg.sv
// Shared ROB definitions: index width, instruction-type encodings, entry layout.
package reorder_buffer_pkg;
  localparam int ROB_WIDTH = 3;

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_STORE  = 2'd1,
    T_BRANCH = 2'd2,
    T_JALR   = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e   typ;
    logic [4:0]  rd;
    logic        pred;
    logic [31:0] alt_pc;
    logic [31:0] val;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order issue, two CDB writeback ports, operand
// search with same-cycle forwarding, in-order commit and mispredict flush.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 issue_valid,
  input  logic [1:0]           issue_type,
  input  logic [4:0]           issue_rd,
  input  logic                 issue_pred_taken,
  input  logic [31:0]          issue_alt_pc,
  output logic [ROB_WIDTH-1:0] issue_rob_id,
  output logic                 full,
  input  logic                 wb_valid_0,
  input  logic [ROB_WIDTH-1:0] wb_rob_id_0,
  input  logic [31:0]          wb_val_0,
  input  logic                 wb_valid_1,
  input  logic [ROB_WIDTH-1:0] wb_rob_id_1,
  input  logic [31:0]          wb_val_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_1,
  input  logic [ROB_WIDTH-1:0] search_rob_id_2,
  output logic                 search_ready_1,
  output logic                 search_ready_2,
  output logic [31:0]          search_val_1,
  output logic [31:0]          search_val_2,
  output logic                 commit_ready,
  output logic [4:0]           commit_reg_id,
  output logic [31:0]          commit_val,
  output logic [ROB_WIDTH-1:0] commit_rob_id,
  output logic                 commit_store,
  output logic                 clear,
  output logic [31:0]          clear_pc
);
  localparam int ROB_SIZE = 1 << ROB_WIDTH;

  rob_entry_t             ent [ROB_SIZE];
  logic [ROB_SIZE-1:0]    busy, ready;
  logic [ROB_WIDTH-1:0]   head, tail;
  logic [ROB_WIDTH:0]     count;
  logic                   issue_ok, wb_ok_0, wb_ok_1, retire, mispredict;
  rob_entry_t             hd;

  assign full         = count == (ROB_WIDTH+1)'(ROB_SIZE);
  assign issue_rob_id = tail;
  assign hd           = ent[head];
  // full is taken from the pre-commit count, so a slot freed this cycle is not reusable yet
  assign issue_ok     = issue_valid && !full && !clear;
  assign wb_ok_0      = wb_valid_0 && busy[wb_rob_id_0] && !clear;
  assign wb_ok_1      = wb_valid_1 && busy[wb_rob_id_1] && !clear;
  assign retire       = !clear && count != '0 && ready[head];
  assign mispredict   = hd.typ == T_JALR || (hd.typ == T_BRANCH && hd.val[0] != hd.pred);

  // Port 0 is applied last so it wins when both CDB ports hit the searched id
  always_comb begin
    search_ready_1 = ready[search_rob_id_1];
    search_val_1   = ent[search_rob_id_1].val;
    search_ready_2 = ready[search_rob_id_2];
    search_val_2   = ent[search_rob_id_2].val;
    if (wb_valid_1 && wb_rob_id_1 == search_rob_id_1) begin
      search_ready_1 = 1'b1;
      search_val_1   = wb_val_1;
    end
    if (wb_valid_1 && wb_rob_id_1 == search_rob_id_2) begin
      search_ready_2 = 1'b1;
      search_val_2   = wb_val_1;
    end
    if (wb_valid_0 && wb_rob_id_0 == search_rob_id_1) begin
      search_ready_1 = 1'b1;
      search_val_1   = wb_val_0;
    end
    if (wb_valid_0 && wb_rob_id_0 == search_rob_id_2) begin
      search_ready_2 = 1'b1;
      search_val_2   = wb_val_0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      busy          <= '0;
      ready         <= '0;
      clear         <= 1'b0;
      clear_pc      <= '0;
      commit_ready  <= 1'b0;
      commit_reg_id <= '0;
      commit_val    <= '0;
      commit_rob_id <= '0;
      commit_store  <= 1'b0;
    end else if (rdy_in) begin
      commit_ready <= retire;
      clear        <= retire && mispredict;
      if (retire) begin
        commit_rob_id <= head;
        commit_val    <= hd.val;
        commit_reg_id <= (hd.typ == T_REG || hd.typ == T_JALR) ? hd.rd : 5'd0;
        commit_store  <= hd.typ == T_STORE;
        if (mispredict) clear_pc <= (hd.typ == T_JALR) ? hd.val : hd.alt_pc;
      end else begin
        commit_reg_id <= '0;
        commit_store  <= 1'b0;
      end
      if (wb_ok_0) begin
        ent[wb_rob_id_0].val <= wb_val_0;
        ready[wb_rob_id_0]   <= 1'b1;
      end
      if (wb_ok_1) begin
        ent[wb_rob_id_1].val <= wb_val_1;
        ready[wb_rob_id_1]   <= 1'b1;
      end
      if (issue_ok) begin
        ent[tail].typ    <= rob_type_e'(issue_type);
        ent[tail].rd     <= issue_rd;
        ent[tail].pred   <= issue_pred_taken;
        ent[tail].alt_pc <= issue_alt_pc;
        ready[tail]      <= 1'b0;
        busy[tail]       <= 1'b1;
        tail             <= tail + 1'b1;
      end
      if (retire) begin
        busy[head]  <= 1'b0;
        ready[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      count <= count + (ROB_WIDTH+1)'(issue_ok) - (ROB_WIDTH+1)'(retire);
      // The branch retires normally; everything younger is discarded
      if (retire && mispredict) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end
    end
  end
endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL expose these ports, clock and reset first: clk_in in 1 system clock; rst_in in 1 reset; rdy_in in 1 low = pause; holds all state and outputs.
REQ-002 The block SHALL run on one clock, clk_in; rst_in SHALL be a synchronous, active-high reset.
REQ-003 Issue ports SHALL be: issue_valid in 1; issue_type in 2 (REG/STORE/BRANCH/JALR); issue_rd in 5; issue_pred_taken in 1; issue_alt_pc in 32 (recovery PC on mispredict); issue_rob_id out ROB_WIDTH (= tail); full out 1.
REQ-004 Writeback ports SHALL be two CDB ports, k=0 (ALU) and k=1 (LSB): wb_valid_k in 1; wb_rob_id_k in ROB_WIDTH; wb_val_k in 32 (branch: bit0 = actual taken; JALR: target PC).
REQ-005 Search ports SHALL be: search_rob_id_1/2 in ROB_WIDTH; search_ready_1/2 out 1; search_val_1/2 out 32.
REQ-006 Commit ports SHALL be: commit_ready out 1; commit_reg_id out 5; commit_val out 32; commit_rob_id out ROB_WIDTH; commit_store out 1 (to LSB).
REQ-007 Flush ports SHALL be: clear out 1; clear_pc out 32.

Function
REQ-008 Storage SHALL be ROB_SIZE = 2^ROB_WIDTH entries in a circular buffer with head, tail and count (ROB_WIDTH+1 bits); pointers wrap modulo ROB_SIZE.
REQ-009 full SHALL be combinational: count == ROB_SIZE.
REQ-010 Issue accepted when issue_valid && !full && !clear: entry[tail] loads type/rd/pred/alt_pc, ready=0; tail++.
REQ-011 Writeback on port k with valid, entry busy and !clear: entry.val <= wb_val_k, ready <= 1; both ports to different ids in one cycle both apply; same id is a protocol error.
REQ-012 search_ready_n SHALL be combinational: entry ready, or a same-cycle wb_valid_k with matching id; search_val_n is the forwarded wb_val_k when forwarding, else entry.val; port 0 wins if both match.
REQ-013 Commit: when count != 0, head entry ready, !clear: retire head, head++, one entry per cycle max.
REQ-014 Commit outputs SHALL be registered, valid the cycle after retirement: commit_ready=1, commit_rob_id=head id, commit_val=entry.val; commit_reg_id=rd for REG/JALR, 0 for STORE/BRANCH; commit_store=1 only for STORE.
REQ-015 In every cycle without retirement commit_ready, commit_reg_id, commit_store SHALL be 0 (a nonzero commit_reg_id always means a real write).
REQ-016 Simultaneous issue and commit SHALL leave count unchanged; issue into a slot freed the same cycle is not allowed (full evaluated before commit).
REQ-017 Mispredict: retiring BRANCH with val[0] != pred_taken, or any JALR, SHALL set clear=1 next cycle with clear_pc = alt_pc (BRANCH) or val (JALR); the branch itself commits normally.
REQ-018 On the retirement edge of a mispredict, head, tail, count SHALL reset to 0 and all ready bits clear; clear is a single-cycle pulse.
REQ-019 While clear=1, issue and writeback inputs SHALL be ignored and no retirement occurs.
REQ-020 While rdy_in=0, no state or output SHALL change, including commit_ready and clear.

Reset
REQ-021 On rst_in: head=tail=count=0, all ready bits 0, clear=0, clear_pc=0, commit_ready=0, commit_reg_id=0, commit_val=0, commit_rob_id=0, commit_store=0.
REQ-022 Reset SHALL take priority over rdy_in and all inputs; reset mid-operation discards every in-flight entry.

Structure
REQ-023 ROB_WIDTH and the 2-bit issue_type encodings SHALL live in the shared defines file; ROB_SIZE is derived locally.
REQ-024 The block SHALL be a single module; no sub-module.

Verification
REQ-025 Issue REG rd=5 to id 0, wb_0 id 0 val 0x1234 -> next-but-one cycle commit_ready=1, commit_reg_id=5, commit_val=0x1234, commit_rob_id=0.
REQ-026 Issue ROB_SIZE entries without writeback -> full=1 after last; further issue ignored; one commit -> full=0; tail wraps to 0.
REQ-027 Wb id 2 val 0x55 same cycle as search_rob_id_1=2 -> search_ready_1=1, search_val_1=0x55 that cycle.
REQ-028 BRANCH pred_taken=0, alt_pc 0x100, wb val 1 -> clear=1 for one cycle, clear_pc=0x100, count=0; younger ready entries never commit.
REQ-029 Issue STORE then REG rd=0 -> both commit with commit_reg_id=0; commit_store=1 only for STORE.
REQ-030 Hold rdy_in=0 with ready head for 3 cycles -> no commit; release -> exactly one commit next cycle.
